synapse_current_gen: RTL

Synaptic input stage directly upstream of the Izhikevich neuron: turns presynaptic spike pulses into the neuron's 18-bit signed input current `I`. Spikes are counted per input over one 4096-cycle neuron update window. At each window boundary a small FSM does three things: decays the stored synaptic current, adds weight × spike-count for every input, and adds a bias. All arithmetic is saturating, in the neuron's Q1.16 format (sign, 1 integer bit, 16 fraction bits; 1.0 = 65536).

---
 rtl/synapse_current_gen_if.sv | 24 ++
 rtl/synapse_current_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/synapse_current_gen_if.sv
// Spike, weight-write, bias and current-output signals shared between the
// synaptic current generator and whatever drives it.
interface synapse_current_gen_if #(
    parameter int N_IN = 4
);
    logic [N_IN-1:0]    spike_in;
    logic               w_wr_en;
    logic [3:0]         w_wr_addr;
    logic signed [17:0] w_wr_data;
    logic signed [17:0] bias;
    logic signed [17:0] I_out;
    logic               i_valid;
    logic               tick;

    modport master (
        output spike_in, w_wr_en, w_wr_addr, w_wr_data, bias,
        input  I_out, i_valid, tick
    );

    modport slave (
        input  spike_in, w_wr_en, w_wr_addr, w_wr_data, bias,
        output I_out, i_valid, tick
    );
endinterface

// File: rtl/synapse_current_gen.sv
// Converts presynaptic spikes into the Izhikevich neuron's Q1.16 input current,
// updating once per 2^TICK_BITS-cycle window with decay, weighted sum and bias.
//
// state | meaning
// IDLE  | counting spikes, waiting for window counter == 0
// DECAY | acc <= syn - (syn >>> DECAY_SHIFT)
// ACCUM | acc += weight[k] * shadow[k], one input per cycle
// DONE  | commit syn and I_out, pulse i_valid
module synapse_current_gen #(
    parameter int N_IN        = 4,
    parameter int DECAY_SHIFT = 3,
    parameter int TICK_BITS   = 12
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    synapse_current_gen_if.slave  bus
);
    localparam int K_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {IDLE, DECAY, ACCUM, DONE} state_t;

    state_t                 state;
    logic [TICK_BITS-1:0]   win_cnt;
    logic [2:0]             live   [N_IN];
    logic [2:0]             shadow [N_IN];
    logic signed [17:0]     weight [N_IN];
    logic signed [17:0]     syn;
    logic signed [23:0]     acc;
    logic [K_W-1:0]         k;

    logic                   take;
    logic signed [23:0]     syn_ext;
    logic signed [23:0]     decayed;
    logic signed [20:0]     w_ext;
    logic signed [20:0]     c_ext;
    logic signed [20:0]     prod;
    logic signed [17:0]     acc_sat;
    logic signed [17:0]     out_sat;

    function automatic logic signed [17:0] sat18(input logic signed [24:0] v);
        if (v > 25'sd131071)
            return 18'sd131071;
        else if (v < -25'sd131072)
            return -18'sd131072;
        else
            return v[17:0];
    endfunction

    assign take    = (state == IDLE) && (win_cnt == '0);
    assign bus.tick = !reset && (win_cnt == '0);

    always_comb begin
        syn_ext = 24'(syn);
        decayed = syn_ext - (syn_ext >>> DECAY_SHIFT);
        w_ext   = 21'(weight[k]);
        c_ext   = 21'({1'b0, shadow[k]});
        prod    = w_ext * c_ext;
        acc_sat = sat18(25'(acc));
        out_sat = sat18(25'(acc_sat) + 25'(bus.bias));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            win_cnt <= '0;
        else
            win_cnt <= win_cnt + 1'b1;
    end

    // Addresses at or above N_IN simply match no entry.
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < N_IN; i++) begin
            if (reset)
                weight[i] <= '0;
            else if (bus.w_wr_en && (bus.w_wr_addr == 4'(i)))
                weight[i] <= bus.w_wr_data;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            acc         <= '0;
            syn         <= '0;
            bus.I_out   <= '0;
            bus.i_valid <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            bus.i_valid <= 1'b0;
            // A spike in the snapshot cycle belongs to the new window.
            for (int i = 0; i < N_IN; i++) begin
                if (take)
                    live[i] <= {2'b00, bus.spike_in[i]};
                else if (bus.spike_in[i] && (live[i] != 3'd7))
                    live[i] <= live[i] + 3'd1;
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        for (int i = 0; i < N_IN; i++)
                            shadow[i] <= live[i];
                        state <= DECAY;
                    end
                end
                DECAY: begin
                    acc   <= decayed;
                    k     <= '0;
                    state <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc + 24'(prod);
                    k   <= k + 1'b1;
                    if (k == K_W'(N_IN - 1))
                        state <= DONE;
                end
                DONE: begin
                    syn         <= acc_sat;
                    bus.I_out   <= out_sat;
                    bus.i_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
